// File: rtl/ids_reg_responder_pkg.sv
// rtl/ids_reg_responder_pkg.sv - shared constants and types for the IDS register-ring responder
package ids_reg_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int REG_SRC_WIDTH  = 2;
    localparam int TAG_WIDTH      = 8;
    localparam int IDX_WIDTH      = ADDR_W - TAG_WIDTH;
    localparam int NUM_SW_REGS    = 4;
    localparam int NUM_HW_REGS    = 4;

    localparam logic [TAG_WIDTH-1:0] BLOCK_TAG     = 8'h01;
    localparam logic [DATA_W-1:0]    BAD_ADDR_DATA = 16'hDEAD;

    typedef enum logic [IDX_WIDTH-1:0] {
        REG_CTRL      = 8'd0,
        REG_CPU_RST   = 8'd1,
        REG_IMEM_ADDR = 8'd2,
        REG_IMEM_DATA = 8'd3,
        REG_PC        = 8'd4,
        REG_PKT_CNT   = 8'd5,
        REG_STATUS_6  = 8'd6,
        REG_STATUS_7  = 8'd7
    } ids_reg_idx_e;

    function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_WIDTH-1:0] tag,
                                                    input logic [IDX_WIDTH-1:0] idx);
        return {tag, idx};
    endfunction

endpackage

// File: rtl/ids_reg_responder_if.sv
// rtl/ids_reg_responder_if.sv - one hop of the UDP register ring
interface ids_reg_responder_if
    import ids_reg_pkg::*;
#(
    parameter int SRC_W = REG_SRC_WIDTH
) ();

    logic              reg_req;
    logic              reg_ack;
    logic              reg_rd_wr_l;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic [SRC_W-1:0]  reg_src;

    modport master (
        output reg_req, reg_ack, reg_rd_wr_l, reg_addr, reg_data, reg_src
    );

    modport slave (
        input reg_req, reg_ack, reg_rd_wr_l, reg_addr, reg_data, reg_src
    );

endinterface

// File: rtl/ids_reg_responder.sv
// rtl/ids_reg_responder.sv - claims tagged ring requests, serves SW/HW register bank, forwards the rest
module ids_reg_responder #(
    parameter int                    UDP_REG_SRC_WIDTH = ids_reg_pkg::REG_SRC_WIDTH,
    parameter int                    TAG_WIDTH         = ids_reg_pkg::TAG_WIDTH,
    parameter logic [TAG_WIDTH-1:0]  BLOCK_TAG         = ids_reg_pkg::BLOCK_TAG,
    parameter int                    NUM_SW_REGS       = ids_reg_pkg::NUM_SW_REGS,
    parameter int                    NUM_HW_REGS       = ids_reg_pkg::NUM_HW_REGS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    ids_reg_responder_if.slave                        ring_in,
    ids_reg_responder_if.master                       ring_out,
    output logic [NUM_SW_REGS*ids_reg_pkg::DATA_W-1:0] sw_regs,
    output logic [NUM_SW_REGS-1:0]                    sw_wr_strobe,
    input  logic [NUM_HW_REGS*ids_reg_pkg::DATA_W-1:0] hw_regs
);
    import ids_reg_pkg::*;

    localparam int IDX_W = ADDR_W - TAG_WIDTH;

    logic [TAG_WIDTH-1:0]   tag;
    logic [IDX_W-1:0]       idx;
    logic                   hit;
    logic [DATA_W-1:0]      rd_data;
    logic [NUM_SW_REGS-1:0] wr_sel;

    assign tag = ring_in.reg_addr[ADDR_W-1 -: TAG_WIDTH];
    assign idx = ring_in.reg_addr[IDX_W-1:0];
    assign hit = ring_in.reg_req && !ring_in.reg_ack && (tag == BLOCK_TAG);

    // Unmapped indices fall through to the bad-address pattern.
    always_comb begin
        rd_data = BAD_ADDR_DATA;
        for (int i = 0; i < NUM_SW_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_data = sw_regs[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_HW_REGS; i++) begin
            if (idx == IDX_W'(NUM_SW_REGS + i)) begin
                rd_data = hw_regs[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_SW_REGS; i++) begin
            wr_sel[i] = hit && !ring_in.reg_rd_wr_l && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_out.reg_req     <= 1'b0;
            ring_out.reg_ack     <= 1'b0;
            ring_out.reg_rd_wr_l <= 1'b0;
            ring_out.reg_addr    <= '0;
            ring_out.reg_data    <= '0;
            ring_out.reg_src     <= '0;
            sw_regs              <= '0;
            sw_wr_strobe         <= '0;
        end else begin
            ring_out.reg_req     <= ring_in.reg_req;
            ring_out.reg_ack     <= ring_in.reg_ack | hit;
            ring_out.reg_rd_wr_l <= ring_in.reg_rd_wr_l;
            ring_out.reg_addr    <= ring_in.reg_addr;
            ring_out.reg_src     <= UDP_REG_SRC_WIDTH'(ring_in.reg_src);
            ring_out.reg_data    <= (hit && ring_in.reg_rd_wr_l) ? rd_data : ring_in.reg_data;
            sw_wr_strobe         <= wr_sel;
            for (int i = 0; i < NUM_SW_REGS; i++) begin
                if (wr_sel[i]) begin
                    sw_regs[i*DATA_W +: DATA_W] <= ring_in.reg_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ids_reg_responder.sv
// tb/tb_ids_reg_responder.sv - directed vector bench for ids_reg_responder
module tb_ids_reg_responder;
    import ids_reg_pkg::*;

    typedef struct {
        logic        req;
        logic        ack;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  src;
        logic        exp_ack;
        logic [15:0] exp_data;
        logic [3:0]  exp_strobe;
        logic [63:0] exp_sw;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] sw_regs;
    logic [3:0]  sw_wr_strobe;
    logic [63:0] hw_regs;

    int pass_cnt  = 0;
    int total_cnt = 0;
    vec_t vecs[$];

    ids_reg_responder_if ring_in_bus ();
    ids_reg_responder_if ring_out_bus ();

    ids_reg_responder dut (
        .clk          (clk),
        .reset        (reset),
        .ring_in      (ring_in_bus.slave),
        .ring_out     (ring_out_bus.master),
        .sw_regs      (sw_regs),
        .sw_wr_strobe (sw_wr_strobe),
        .hw_regs      (hw_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic req, input logic ack, input logic rd,
                         input logic [15:0] addr, input logic [15:0] data, input logic [1:0] src);
        ring_in_bus.reg_req     = req;
        ring_in_bus.reg_ack     = ack;
        ring_in_bus.reg_rd_wr_l = rd;
        ring_in_bus.reg_addr    = addr;
        ring_in_bus.reg_data    = data;
        ring_in_bus.reg_src     = src;
    endtask

    function automatic vec_t mk(input logic req, input logic ack, input logic rd,
                                input logic [15:0] addr, input logic [15:0] data,
                                input logic [1:0] src, input logic exp_ack,
                                input logic [15:0] exp_data, input logic [3:0] exp_strobe,
                                input logic [63:0] exp_sw);
        vec_t v;
        v.req = req; v.ack = ack; v.rd = rd; v.addr = addr; v.data = data; v.src = src;
        v.exp_ack = exp_ack; v.exp_data = exp_data; v.exp_strobe = exp_strobe; v.exp_sw = exp_sw;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " ring"}, {ring_out_bus.reg_req, ring_out_bus.reg_ack, ring_out_bus.reg_rd_wr_l,
                               ring_out_bus.reg_addr, ring_out_bus.reg_data, ring_out_bus.reg_src}, 64'h0);
        check({tag, " sw_regs"}, sw_regs, 64'h0);
        check({tag, " strobe"}, {60'h0, sw_wr_strobe}, 64'h0);
    endtask

    initial begin
        hw_regs = {16'h4444, 16'h3333, 16'hBEEF, 16'h1111};
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0100, 16'hFFFF, 2'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0);
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("reset_idle");

        //        req  ack  rd   addr      data      src  eack edata     estrobe  esw
        vecs.push_back(mk(1, 0, 0, 16'h0102, 16'h1234, 1, 1, 16'h1234, 4'b0100, 64'h0000_1234_0000_0000));
        vecs.push_back(mk(1, 0, 1, 16'h0102, 16'h0000, 2, 1, 16'h1234, 4'b0000, 64'h0000_1234_0000_0000));
        vecs.push_back(mk(1, 0, 1, 16'h0105, 16'h0000, 0, 1, 16'hBEEF, 4'b0000, 64'h0000_1234_0000_0000));
        vecs.push_back(mk(1, 0, 0, 16'h0105, 16'h0000, 3, 1, 16'h0000, 4'b0000, 64'h0000_1234_0000_0000));
        vecs.push_back(mk(1, 0, 1, 16'h0109, 16'h0000, 1, 1, 16'hDEAD, 4'b0000, 64'h0000_1234_0000_0000));
        vecs.push_back(mk(1, 0, 0, 16'h0203, 16'h5555, 2, 0, 16'h5555, 4'b0000, 64'h0000_1234_0000_0000));
        vecs.push_back(mk(1, 1, 0, 16'h0101, 16'h7777, 1, 1, 16'h7777, 4'b0000, 64'h0000_1234_0000_0000));
        vecs.push_back(mk(1, 0, 0, 16'h0100, 16'hAAAA, 0, 1, 16'hAAAA, 4'b0001, 64'h0000_1234_0000_AAAA));
        vecs.push_back(mk(1, 0, 1, 16'h0100, 16'h0000, 0, 1, 16'hAAAA, 4'b0000, 64'h0000_1234_0000_AAAA));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 4'b0000, 64'h0000_1234_0000_AAAA));
        vecs.push_back(mk(1, 0, 1, 16'h0104, 16'h0000, 1, 1, 16'h1111, 4'b0000, 64'h0000_1234_0000_AAAA));
        vecs.push_back(mk(1, 0, 1, 16'h0107, 16'h0000, 2, 1, 16'h4444, 4'b0000, 64'h0000_1234_0000_AAAA));
        vecs.push_back(mk(1, 0, 1, 16'h0108, 16'h0000, 3, 1, 16'hDEAD, 4'b0000, 64'h0000_1234_0000_AAAA));
        vecs.push_back(mk(1, 0, 1, 16'h0103, 16'h0000, 0, 1, 16'h0000, 4'b0000, 64'h0000_1234_0000_AAAA));
        vecs.push_back(mk(1, 0, 0, 16'h0103, 16'h5A5A, 1, 1, 16'h5A5A, 4'b1000, 64'h5A5A_1234_0000_AAAA));
        vecs.push_back(mk(0, 0, 1, 16'h0101, 16'h9999, 2, 0, 16'h9999, 4'b0000, 64'h5A5A_1234_0000_AAAA));
        vecs.push_back(mk(1, 1, 1, 16'h0200, 16'hCAFE, 3, 1, 16'hCAFE, 4'b0000, 64'h5A5A_1234_0000_AAAA));
        vecs.push_back(mk(1, 0, 0, 16'h0106, 16'hFFFF, 0, 1, 16'hFFFF, 4'b0000, 64'h5A5A_1234_0000_AAAA));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].ack, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].src);
            @(posedge clk);
            #1;
            check($sformatf("v%0d ack", i), {63'h0, ring_out_bus.reg_ack}, {63'h0, vecs[i].exp_ack});
            check($sformatf("v%0d data", i), {48'h0, ring_out_bus.reg_data}, {48'h0, vecs[i].exp_data});
            check($sformatf("v%0d strobe", i), {60'h0, sw_wr_strobe}, {60'h0, vecs[i].exp_strobe});
            check($sformatf("v%0d sw_regs", i), sw_regs, vecs[i].exp_sw);
            check($sformatf("v%0d passthru", i),
                  {44'h0, ring_out_bus.reg_req, ring_out_bus.reg_rd_wr_l, ring_out_bus.reg_addr, ring_out_bus.reg_src},
                  {44'h0, vecs[i].req, vecs[i].rd, vecs[i].addr, vecs[i].src});
        end

        // Write lands, then reset arrives together with a second write that must be dropped.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, make_addr(BLOCK_TAG, REG_CPU_RST), 16'hBBBB, 2'd1);
        @(posedge clk);
        #1;
        check("rst_seq pre ack", {63'h0, ring_out_bus.reg_ack}, 64'h1);
        check("rst_seq pre sw", sw_regs, 64'h5A5A_1234_BBBB_AAAA);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, make_addr(BLOCK_TAG, REG_CTRL), 16'h1111, 2'd2);
        @(posedge clk);
        #1;
        check_all_zero("rst_seq during");
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0);
        @(posedge clk);
        #1;
        check_all_zero("rst_seq after");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ids_reg_responder.md
# ids_reg_responder

Register-ring responder for the IDS block: it sits in series on the UDP register ring and claims any request whose address tag equals the block tag. It services reads and writes to a small bank of software-writable control registers and hardware-driven status registers. Non-matching or already-acknowledged traffic is forwarded downstream with one cycle of latency. Its software registers drive the pipeline/packet-path control inputs, and its hardware registers expose pipeline and packet-path status.

## Interface
Parameters:
- `UDP_REG_SRC_WIDTH`, 2, width of the request source id.
- `TAG_WIDTH`, 8, address bits `[ADDR_W-1 : ADDR_W-TAG_WIDTH]` holding the block tag.
- `BLOCK_TAG`, 8'h01, tag value this block claims.
- `NUM_SW_REGS`, 4, read/write registers at index 0..NUM_SW_REGS-1.
- `NUM_HW_REGS`, 4, read-only registers at index NUM_SW_REGS..NUM_SW_REGS+NUM_HW_REGS-1.

Ports (ADDR_W = `` `UDP_REG_ADDR_WIDTH `` = 16; DATA_W = `` `CPCI_NF2_DATA_WIDTH `` = 16):
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `reg_req_in`  in  1  request valid; each cycle high is one transaction.
- `reg_ack_in`  in  1  request already acknowledged upstream.
- `reg_rd_wr_L_in`  in  1  1 = read, 0 = write.
- `reg_addr_in`  in  ADDR_W  tag + register index.
- `reg_data_in`  in  DATA_W  write data / upstream read data.
- `reg_src_in`  in  UDP_REG_SRC_WIDTH  requester id.
- `reg_req_out`, `reg_ack_out`, `reg_rd_wr_L_out`, `reg_addr_out`, `reg_data_out`, `reg_src_out`  out  same widths  registered ring outputs.
- `sw_regs`  out  NUM_SW_REGS*DATA_W  software register contents; reg i at `[i*DATA_W +: DATA_W]`.
- `sw_wr_strobe`  out  NUM_SW_REGS  one-cycle pulse per software register written.
- `hw_regs`  in  NUM_HW_REGS*DATA_W  status values, sampled on read.

## Operation
- Hit when `reg_req_in` && !`reg_ack_in` && tag == BLOCK_TAG.
- Index = low ADDR_W-TAG_WIDTH address bits.
- Hit on a software index:
  - Write: store `reg_data_in`, pulse `sw_wr_strobe[idx]`.
  - Read: return the stored value.
- Hit on a hardware index:
  - Read: return `hw_regs` slice sampled in the request cycle.
  - Write: ignored, no state change.
- Hit on an index ≥ NUM_SW_REGS+NUM_HW_REGS: write ignored; read returns 16'hDEAD.
- Every hit: `reg_ack_out`=1; req/rd_wr_L/addr/src copied from the inputs.
- `reg_data_out` on a hit:
  - Read: the read value.
  - Write: `reg_data_in` unchanged.
- Non-hit (no request, tag mismatch, or `reg_ack_in`=1): all six ring outputs = inputs delayed one cycle. No register change, no strobe.
- Already-acked request with a matching tag: forwarded untouched. Never double-acked, never written.
- Back-to-back requests on consecutive cycles each serviced independently, no stall.
- Read of a software register in the cycle after its write returns the new value.

## Timing
- Latency: exactly 1 cycle from input to every ring output, hit or miss.
- `sw_wr_strobe[i]` rises in the same cycle as the corresponding `reg_ack_out`, for 1 cycle.
- `sw_regs` update on the same edge that raises `reg_ack_out`.
- Reset values:
  - All ring outputs 0.
  - `sw_regs` all 0.
  - `sw_wr_strobe` 0.
- Reset asserted mid-transaction: the in-flight request is dropped, no ack is produced, and outputs are 0 on the cycle after reset is sampled. A request presented while `reset`=1 is discarded.
- No state machine beyond the single output register stage. No combinational path from inputs to outputs.

## Structure
- Shared package (`ids_reg_pkg`):
  - BLOCK_TAG and TAG_WIDTH constants.
  - Register index constants (CTRL=0, CPU_RST=1, IMEM_ADDR=2, IMEM_DATA=3, PC=4, PKT_CNT=5, …).
  - 16'hDEAD bad-address constant.
- No sub-module: a flat, single-stage registered design.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0, `sw_regs`=0, no ack.
- Write 16'h1234 to tag 8'h01 idx 2 -> next cycle `reg_ack_out`=1, `reg_data_out`=16'h1234, `sw_wr_strobe`=4'b0100 for 1 cycle, `sw_regs[47:32]`=16'h1234. Read idx 2 the following cycle -> ack, data 16'h1234.
- Read idx 5 with `hw_regs[31:16]`=16'hBEEF -> ack, data 16'hBEEF. Write 16'h0000 to idx 5 -> ack, no strobe, no `sw_regs` change.
- Read idx 9 -> ack, data 16'hDEAD. Request with tag 8'h02, data 16'h5555 -> forwarded 1 cycle later, ack 0, data 16'h5555.
- Matching write with `reg_ack_in`=1 -> forwarded with ack 1, `sw_regs` unchanged, no strobe.
- Back-to-back write idx0 = 16'hAAAA then read idx0 -> two acks on consecutive cycles, second returns 16'hAAAA. Assert `reset` on the cycle after a new write -> no ack, outputs 0, `sw_regs` 0.
